uart_rx: RTL and testbench

UART receiver with 16x oversampling and a fixed frame of 1 start bit, `SIZE_TRAMA_BIT` data bits (LSB first) and 1 stop bit. It is the receive-side counterpart of the UART transmitter and shares the same baud tick generator, which supplies one-cycle `i_tick` pulses at 16x baud. It deserializes the frame into a parallel word and flags each completed frame with a one-cycle done pulse. A stop bit sampled low is reported as a one-cycle framing-error pulse instead.

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 1 start bit, SIZE_TRAMA_BIT data bits LSB first, 1 stop bit.
// A good frame updates o_data with a one-cycle o_rx_done; a low stop bit gives a one-cycle o_frame_err.
module uart_rx #(
    parameter int SIZE_TRAMA_BIT   = 8,
    parameter int SIZE_BIT_COUNTER = 3
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_tick,
    input  logic                      i_rx,
    output logic [SIZE_TRAMA_BIT-1:0] o_data,
    output logic                      o_rx_done,
    output logic                      o_frame_err,
    output logic [3:0]                o_state
);

    // One-cold state codes; any other code falls back to IDLE.
    localparam logic [3:0] S_IDLE  = 4'b1110;
    localparam logic [3:0] S_START = 4'b1101;
    localparam logic [3:0] S_DATA  = 4'b1011;
    localparam logic [3:0] S_STOP  = 4'b0111;

    localparam logic [SIZE_BIT_COUNTER-1:0] LAST_BIT = SIZE_BIT_COUNTER'(SIZE_TRAMA_BIT - 1);

    logic                        rx_meta_q, rx_s_q, rx_d_q;
    logic [3:0]                  state_q, state_d;
    logic [3:0]                  tick_q, tick_d;
    logic [SIZE_BIT_COUNTER-1:0] bit_q, bit_d;
    logic [SIZE_TRAMA_BIT-1:0]   shift_q, shift_d;
    logic [SIZE_TRAMA_BIT-1:0]   data_q, data_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;

    logic falling_edge;
    logic mid_sample;
    logic end_sample;
    logic last_bit;

    assign falling_edge = rx_d_q & ~rx_s_q;
    assign mid_sample   = i_tick && (tick_q == 4'd7);
    assign end_sample   = i_tick && (tick_q == 4'd15);
    assign last_bit     = (bit_q == LAST_BIT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (falling_edge) state_d = S_START;
            S_START: if (mid_sample) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA:  if (end_sample && last_bit) state_d = S_STOP;
            S_STOP:  if (end_sample) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Ticks are ignored here; the counter is only cleared by a new start edge.
                if (falling_edge) tick_d = '0;
            end
            S_START: begin
                if (i_tick) begin
                    if (tick_q == 4'd7) begin
                        if (!rx_s_q) begin
                            tick_d = '0;
                            bit_d  = '0;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (tick_q == 4'd15) begin
                        shift_d = {rx_s_q, shift_q[SIZE_TRAMA_BIT-1:1]};
                        tick_d  = '0;
                        if (!last_bit) bit_d = bit_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (i_tick) begin
                    if (tick_q == 4'd15) begin
                        if (rx_s_q) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = err_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a bit-period/sample-point model of the serial line.
module tb_uart_rx;
  localparam int N = 8;
  typedef int per_t [10];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         i_reset;
  logic         i_tick;
  logic         i_rx;
  logic [N-1:0] o_data;
  logic         o_rx_done;
  logic         o_frame_err;
  logic [3:0]   o_state;

  uart_rx #(.SIZE_TRAMA_BIT(N), .SIZE_BIT_COUNTER(3)) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_tick(i_tick),
    .i_rx(i_rx),
    .o_data(o_data),
    .o_rx_done(o_rx_done),
    .o_frame_err(o_frame_err),
    .o_state(o_state)
  );

  int checks = 0;
  int failures = 0;
  int phase = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int exp_done = 0;
  int exp_err = 0;
  logic [N-1:0] got_q[$];
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_good = '0;
  per_t std_per;
  per_t jit_per;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (o_rx_done) begin
      done_cnt++;
      got_q.push_back(o_data);
    end
    if (o_frame_err) err_cnt++;
    if (o_rx_done && o_frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; ticks come every 4th clock without interruption.
  task automatic step();
    @(negedge clk);
    i_tick = (phase == 3);
    phase = (phase + 1) % 4;
  endtask

  task automatic hold_ticks(input int n);
    repeat (n * 4) step();
  endtask

  // Line model: sample k sits 8 + 16k ticks after the start edge; read whatever bit covers it.
  function automatic logic [N:0] model(input logic [N-1:0] d, input logic stop, input per_t per);
    logic bits [10];
    int bound [11];
    logic [N:0] res;
    bits[0] = 1'b0;
    for (int i = 0; i < N; i++) bits[i+1] = d[i];
    bits[9] = stop;
    bound[0] = 0;
    for (int i = 0; i < 10; i++) bound[i+1] = bound[i] + per[i];
    res = '0;
    for (int k = 1; k < 10; k++) begin
      int pos;
      pos = 8 + 16 * k;
      for (int s = 0; s < 10; s++)
        if (pos >= bound[s] && pos < bound[s+1]) res[k-1] = bits[s];
    end
    return res;
  endfunction

  task automatic send_frame(input logic [N-1:0] d, input logic stop, input per_t per);
    logic [N:0] r;
    r = model(d, stop, per);
    i_rx = 1'b0;
    hold_ticks(per[0]);
    for (int i = 0; i < N; i++) begin
      i_rx = d[i];
      hold_ticks(per[i+1]);
    end
    i_rx = stop;
    hold_ticks(per[9]);
    if (r[N]) begin
      exp_done++;
      exp_q.push_back(r[N-1:0]);
      last_good = r[N-1:0];
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_done_cnt"}, done_cnt, exp_done);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_qlen"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    check({tag, "_data_hold"}, 32'(o_data), 32'(last_good));
  endtask

  initial begin
    logic [N-1:0] rd;
    logic         rs;
    for (int i = 0; i < 10; i++) begin
      std_per[i] = 16;
      jit_per[i] = (i % 2 == 0) ? 15 : 17;
    end
    i_reset = 1'b1;
    i_tick  = 1'b0;
    i_rx    = 1'b1;
    repeat (5) step();
    i_reset = 1'b0;
    step();
    check("reset_data", 32'(o_data), 32'h0);
    check("reset_done", 32'(o_rx_done), 32'h0);
    check("reset_err", 32'(o_frame_err), 32'h0);
    check("reset_state", 32'(o_state), 32'he);

    // Single frame
    hold_ticks(4);
    send_frame(8'hA5, 1'b1, std_per);
    hold_ticks(4);
    check_frames("single");

    // False start: short low pulse, sampled high at mid start bit
    i_rx = 1'b0;
    hold_ticks(4);
    i_rx = 1'b1;
    hold_ticks(20);
    check("false_start_state", 32'(o_state), 32'he);
    check_frames("false_start");

    // Framing error, then a held break
    send_frame(8'h3C, 1'b0, std_per);
    check_frames("frame_err");
    i_rx = 1'b0;
    hold_ticks(40);
    i_rx = 1'b1;
    hold_ticks(10);
    check_frames("break");

    // Back-to-back frames
    send_frame(8'h00, 1'b1, std_per);
    send_frame(8'hFF, 1'b1, std_per);
    hold_ticks(4);
    check_frames("b2b");

    // Reset during data bit 3 of 0x81
    i_rx = 1'b0;
    hold_ticks(16);
    for (int i = 0; i < 3; i++) begin
      i_rx = (i == 0);
      hold_ticks(16);
    end
    i_rx = 1'b0;
    hold_ticks(8);
    i_reset = 1'b1;
    i_rx = 1'b1;
    step();
    i_reset = 1'b0;
    last_good = '0;
    hold_ticks(20);
    check("midreset_state", 32'(o_state), 32'he);
    check_frames("midreset");
    send_frame(8'h81, 1'b1, std_per);
    hold_ticks(4);
    check_frames("after_reset");

    // Tick jitter: alternating 15/17 tick bit periods
    send_frame(8'h5A, 1'b1, jit_per);
    hold_ticks(4);
    check_frames("jitter");

    // Randomized frames with occasional bad stop bits and random gaps
    for (int f = 0; f < 8; f++) begin
      rd = N'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rs, std_per);
      i_rx = 1'b1;
      hold_ticks($urandom_range(0, 5));
    end
    hold_ticks(4);
    check_frames("random");

    check("never_both", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
